host_interface: RTL and testbench

HOST_INTERFACE -- requirements
Module: host_interface

---
 rtl/host_interface.sv | 206 ++++++++++++++++++++
 tb/tb_host_interface.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_interface.sv
// Host-side front end for the PE array: forwards configuration writes, launches
// and tracks one computation, and fetches single activation words on request.
module host_interface #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  output logic              write_rdy,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  output logic              read_rdy,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              read_data_rdy,
  output logic              read_data_vld,
  output logic [27:0]       read_data,
  output logic              interrupt,
  output logic              cfg_wr_en,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [DATA_W-1:0] cfg_data,
  output logic              start,
  input  logic              calc_done,
  output logic              act_rd_req,
  output logic [5:0]        act_rd_pe,
  output logic [5:0]        act_rd_addr,
  input  logic              act_rd_vld,
  input  logic [15:0]       act_rd_data
);

  localparam logic [ADDR_W-1:0] CMD_START = ADDR_W'(16'h8000);
  localparam logic [ADDR_W-1:0] CMD_CLEAR = ADDR_W'(16'h8002);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2,
    R_RESP = 2'd3
  } rd_state_t;

  ctrl_state_t r_ctrl_state;
  ctrl_state_t w_ctrl_next;
  rd_state_t   r_rd_state;
  rd_state_t   w_rd_next;

  logic              w_write_rdy;
  logic              w_ctrl_busy;
  logic              w_wr_acc;
  logic              w_wr_cfg;
  logic              w_wr_start;
  logic              w_wr_clear;

  logic              w_read_rdy;
  logic              w_rd_acc;
  logic              w_rd_capture;
  logic              w_act_rd_req;
  logic              w_read_data_vld;

  logic              r_start;
  logic              r_interrupt;
  logic              r_cfg_wr_en;
  logic [ADDR_W-1:0] r_cfg_addr;
  logic [DATA_W-1:0] r_cfg_data;
  logic [5:0]        r_rd_pe;
  logic [5:0]        r_rd_act;
  logic [27:0]       r_read_data;

  // Bits [9:6] of a read address carry no meaning for an activation fetch.
  logic              w_unused_rd_addr_bits;
  assign w_unused_rd_addr_bits = ^read_addr[9:6];

  // ---------------------------------------------------------------- write side
  assign w_wr_acc   = write_en & w_write_rdy;
  assign w_wr_cfg   = w_wr_acc & ~write_addr[15];
  assign w_wr_start = w_wr_acc & (write_addr == CMD_START) & write_data[0];
  assign w_wr_clear = w_wr_acc & (write_addr == CMD_CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      r_ctrl_state <= IDLE;
    end else begin
      r_ctrl_state <= w_ctrl_next;
    end
  end

  always_comb begin
    // NOTE: the default assignment up front covers every path, so no latch is inferred.
    w_ctrl_next = r_ctrl_state;
    case (r_ctrl_state)
      IDLE: if (w_wr_start) w_ctrl_next = BUSY;
      BUSY: if (calc_done)  w_ctrl_next = DONE;
      DONE: begin
        if (w_wr_start)      w_ctrl_next = BUSY;
        else if (w_wr_clear) w_ctrl_next = IDLE;
      end
      default: w_ctrl_next = IDLE;
    endcase
  end

  always_comb begin
    w_write_rdy = (r_ctrl_state != BUSY);
    w_ctrl_busy = (r_ctrl_state == BUSY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start     <= 1'b0;
      r_cfg_wr_en <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_interrupt <= 1'b0;
    end else begin
      r_start     <= w_wr_start;
      r_cfg_wr_en <= w_wr_cfg;
      if (w_wr_cfg) begin
        r_cfg_addr <= write_addr;
        r_cfg_data <= write_data;
      end
      // Clearing and setting can never coincide: writes are refused while BUSY.
      if (w_wr_start | w_wr_clear) begin
        r_interrupt <= 1'b0;
      end else if (w_ctrl_busy & calc_done) begin
        r_interrupt <= 1'b1;
      end
    end
  end

  // ----------------------------------------------------------------- read side
  assign w_rd_acc     = read_en & w_read_rdy;
  assign w_rd_capture = (r_rd_state == R_WAIT) & act_rd_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
    end else begin
      r_rd_state <= w_rd_next;
    end
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_rd_acc)      w_rd_next = R_REQ;
      R_REQ:                      w_rd_next = R_WAIT;
      R_WAIT:  if (act_rd_vld)    w_rd_next = R_RESP;
      R_RESP:  if (read_data_rdy) w_rd_next = R_IDLE;
      default:                    w_rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_read_rdy      = (r_rd_state == R_IDLE) & ~w_ctrl_busy;
    w_act_rd_req    = (r_rd_state == R_REQ);
    w_read_data_vld = (r_rd_state == R_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pe     <= '0;
      r_rd_act    <= '0;
      r_read_data <= '0;
    end else begin
      if (w_rd_acc) begin
        r_rd_pe  <= read_addr[15:10];
        r_rd_act <= read_addr[5:0];
      end
      // Activation index = act_addr*64 + pe_idx, i.e. the two fields swapped.
      if (w_rd_capture) begin
        r_read_data <= {r_rd_act, r_rd_pe, act_rd_data};
      end
    end
  end

  // ------------------------------------------------------------------- outputs
  assign write_rdy     = w_write_rdy;
  assign read_rdy      = w_read_rdy;
  assign read_data_vld = w_read_data_vld;
  assign read_data     = r_read_data;
  assign interrupt     = r_interrupt;
  assign cfg_wr_en     = r_cfg_wr_en;
  assign cfg_addr      = r_cfg_addr;
  assign cfg_data      = r_cfg_data;
  assign start         = r_start;
  assign act_rd_req    = w_act_rd_req;
  assign act_rd_pe     = r_rd_pe;
  assign act_rd_addr   = r_rd_act;

  // Handshake invariants; concurrent assertions are ignored by synthesis.
  a_start_pulse: assert property (@(posedge clk) disable iff (rst)
    start |=> !start);
  a_fetch_pulse: assert property (@(posedge clk) disable iff (rst)
    act_rd_req |=> !act_rd_req);
  a_resp_hold: assert property (@(posedge clk) disable iff (rst)
    (read_data_vld && !read_data_rdy) |=> (read_data_vld && $stable(read_data)));
  a_no_read_busy: assert property (@(posedge clk) disable iff (rst)
    !(read_rdy && w_ctrl_busy));

endmodule

// File: tb/tb_host_interface.sv
// Bench for host_interface: reset values, tabled write/read vectors, hand-built
// control/backpressure/reset sequences, then a randomized run against a model.
module tb_host_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en;
  logic        write_rdy;
  logic [15:0] write_addr;
  logic [31:0] write_data;
  logic        read_en;
  logic        read_rdy;
  logic [15:0] read_addr;
  logic        read_data_rdy;
  logic        read_data_vld;
  logic [27:0] read_data;
  logic        interrupt;
  logic        cfg_wr_en;
  logic [15:0] cfg_addr;
  logic [31:0] cfg_data;
  logic        start;
  logic        calc_done;
  logic        act_rd_req;
  logic [5:0]  act_rd_pe;
  logic [5:0]  act_rd_addr;
  logic        act_rd_vld;
  logic [15:0] act_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  host_interface #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .write_en(write_en), .write_rdy(write_rdy),
    .write_addr(write_addr), .write_data(write_data),
    .read_en(read_en), .read_rdy(read_rdy), .read_addr(read_addr),
    .read_data_rdy(read_data_rdy), .read_data_vld(read_data_vld),
    .read_data(read_data), .interrupt(interrupt),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .calc_done(calc_done),
    .act_rd_req(act_rd_req), .act_rd_pe(act_rd_pe), .act_rd_addr(act_rd_addr),
    .act_rd_vld(act_rd_vld), .act_rd_data(act_rd_data)
  );

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic        exp_cfg;
    logic        exp_start;
  } wr_vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] act_data;
    logic [5:0]  exp_pe;
    logic [5:0]  exp_aa;
    logic [27:0] exp_rdata;
  } rd_vec_t;

  wr_vec_t wr_tab[7];
  rd_vec_t rd_tab[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write_en = 1'b0; write_addr = '0; write_data = '0;
    read_en = 1'b0; read_addr = '0; read_data_rdy = 1'b0;
    calc_done = 1'b0; act_rd_vld = 1'b0; act_rd_data = '0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " write_rdy"}, write_rdy, 1);
    check({tag, " read_rdy"}, read_rdy, 1);
    check({tag, " read_data_vld"}, read_data_vld, 0);
    check({tag, " read_data"}, read_data, 0);
    check({tag, " interrupt"}, interrupt, 0);
    check({tag, " start"}, start, 0);
    check({tag, " cfg_wr_en"}, cfg_wr_en, 0);
    check({tag, " cfg_addr"}, cfg_addr, 0);
    check({tag, " cfg_data"}, cfg_data, 0);
    check({tag, " act_rd_req"}, act_rd_req, 0);
    check({tag, " act_rd_pe"}, act_rd_pe, 0);
    check({tag, " act_rd_addr"}, act_rd_addr, 0);
  endtask

  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    write_en = 1'b1; write_addr = a; write_data = d;
    tick();
    write_en = 1'b0;
  endtask

  // Read with the PE array answering in the first wait cycle, then hold off the
  // host for 'hold' cycles before it takes the data.
  task automatic do_read(input string tag, input rd_vec_t v, input int hold);
    check({tag, " read_rdy before"}, read_rdy, 1);
    read_en = 1'b1; read_addr = v.addr;
    tick();
    read_en = 1'b0; read_addr = 16'($urandom);
    check({tag, " act_rd_req"}, act_rd_req, 1);
    check({tag, " act_rd_pe"}, act_rd_pe, v.exp_pe);
    check({tag, " act_rd_addr"}, act_rd_addr, v.exp_aa);
    check({tag, " read_rdy in flight"}, read_rdy, 0);
    tick();
    check({tag, " act_rd_req one cycle"}, act_rd_req, 0);
    check({tag, " vld early"}, read_data_vld, 0);
    act_rd_vld = 1'b1; act_rd_data = v.act_data;
    tick();
    act_rd_vld = 1'b0; act_rd_data = 16'($urandom);
    check({tag, " vld at latency 3"}, read_data_vld, 1);
    check({tag, " read_data"}, read_data, v.exp_rdata);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, " vld held"}, read_data_vld, 1);
      check({tag, " data held"}, read_data, v.exp_rdata);
      check({tag, " read_rdy held"}, read_rdy, 0);
    end
    read_data_rdy = 1'b1;
    tick();
    read_data_rdy = 1'b0;
    check({tag, " vld dropped"}, read_data_vld, 0);
    check({tag, " read_rdy after"}, read_rdy, 1);
  endtask

  // Abstract model state for the randomized run.
  bit          m_busy, m_intr, m_cfg_due, m_start_due;
  bit          m_rd_out, m_resp_given, drove_resp, wr_acc, rd_acc;
  logic [15:0] m_cfg_a;
  logic [31:0] m_cfg_d;
  logic [5:0]  m_pe, m_aa;
  logic [27:0] m_rdata;
  logic [11:0] idx12;
  int          req_cyc, vld_cyc, wait_cnt;
  bit          exp_req, exp_vld;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_tab[0] = '{16'h0012, 32'hDEADBEEF, 1'b1, 1'b0};
    wr_tab[1] = '{16'h7FFF, 32'h00000001, 1'b1, 1'b0};
    wr_tab[2] = '{16'h0000, 32'hFFFFFFFF, 1'b1, 1'b0};
    wr_tab[3] = '{16'h8004, 32'h00000001, 1'b0, 1'b0};
    wr_tab[4] = '{16'h8000, 32'h00000002, 1'b0, 1'b0};
    wr_tab[5] = '{16'hFFFF, 32'h00000001, 1'b0, 1'b0};
    wr_tab[6] = '{16'h8002, 32'h00000001, 1'b0, 1'b0};

    rd_tab[0] = '{16'h0C05, 16'h1234, 6'd3,  6'd5,  28'h1431234};
    rd_tab[1] = '{16'hFFFF, 16'hABCD, 6'd63, 6'd63, 28'hFFFABCD};
    rd_tab[2] = '{16'h0000, 16'h0000, 6'd0,  6'd0,  28'h0000000};
    rd_tab[3] = '{16'h03C0, 16'hFFFF, 6'd0,  6'd0,  28'h000FFFF};
    rd_tab[4] = '{16'h0401, 16'h0001, 6'd1,  6'd1,  28'h0410001};
    rd_tab[5] = '{16'h8020, 16'h5A5A, 6'd32, 6'd32, 28'h8205A5A};

    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    check_reset_outs("in reset");
    rst = 1'b0;
    tick();
    check_reset_outs("after reset");

    // Tabled writes from IDLE.
    for (int i = 0; i < 7; i++) begin
      host_write(wr_tab[i].addr, wr_tab[i].data);
      check($sformatf("wr%0d cfg_wr_en", i), cfg_wr_en, wr_tab[i].exp_cfg);
      if (wr_tab[i].exp_cfg) begin
        check($sformatf("wr%0d cfg_addr", i), cfg_addr, wr_tab[i].addr);
        check($sformatf("wr%0d cfg_data", i), cfg_data, wr_tab[i].data);
      end
      check($sformatf("wr%0d start", i), start, wr_tab[i].exp_start);
      check($sformatf("wr%0d write_rdy", i), write_rdy, 1);
      check($sformatf("wr%0d interrupt", i), interrupt, 0);
      tick();
      check($sformatf("wr%0d cfg pulse ends", i), cfg_wr_en, 0);
    end

    // Tabled reads from IDLE.
    for (int i = 0; i < 6; i++) do_read($sformatf("rd%0d", i), rd_tab[i], 0);

    // Start computation; writes and reads are refused while busy.
    host_write(16'h8000, 32'h1);
    check("go start", start, 1);
    check("go write_rdy", write_rdy, 0);
    check("go read_rdy", read_rdy, 0);
    check("go cfg_wr_en", cfg_wr_en, 0);
    write_en = 1'b1; write_addr = 16'h0033; write_data = 32'h77;
    read_en = 1'b1; read_addr = 16'h0C05;
    tick();
    idle_inputs();
    check("busy start pulse ends", start, 0);
    check("busy read ignored", act_rd_req, 0);
    tick();
    check("busy write ignored", cfg_wr_en, 0);
    check("busy read still ignored", act_rd_req, 0);
    check("busy write_rdy", write_rdy, 0);
    check("busy interrupt", interrupt, 0);
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    check("done interrupt", interrupt, 1);
    check("done write_rdy", write_rdy, 1);
    check("done read_rdy", read_rdy, 1);
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    check("done stray calc_done", interrupt, 1);

    // Activation read in DONE with backpressure on the response.
    do_read("done read", rd_tab[0], 5);
    check("interrupt kept over read", interrupt, 1);

    // Clear from DONE; a stray calc_done in IDLE must not raise interrupt.
    host_write(16'h8002, 32'h0);
    check("clear interrupt", interrupt, 0);
    check("clear write_rdy", write_rdy, 1);
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    tick();
    check("idle stray calc_done", interrupt, 0);

    // Restart from DONE clears a pending interrupt.
    host_write(16'h8000, 32'h1);
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    check("second done interrupt", interrupt, 1);
    host_write(16'h8000, 32'h3);
    check("restart clears interrupt", interrupt, 0);
    check("restart start", start, 1);
    check("restart write_rdy", write_rdy, 0);
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    host_write(16'h8002, 32'h0);
    check("second clear", interrupt, 0);

    // Same-cycle write and read are both taken.
    write_en = 1'b1; write_addr = 16'h0100; write_data = 32'hCAFE0001;
    read_en = 1'b1; read_addr = 16'h0842;
    tick();
    idle_inputs();
    check("dual cfg_wr_en", cfg_wr_en, 1);
    check("dual cfg_data", cfg_data, 32'hCAFE0001);
    check("dual act_rd_req", act_rd_req, 1);
    check("dual act_rd_pe", act_rd_pe, 2);
    check("dual act_rd_addr", act_rd_addr, 2);
    tick();
    act_rd_vld = 1'b1; act_rd_data = 16'h0F0F;
    tick();
    act_rd_vld = 1'b0;
    check("dual read_data", read_data, 28'h0820F0F);
    read_data_rdy = 1'b1;
    tick();
    read_data_rdy = 1'b0;

    // Reset while waiting for the PE array: the late response is dropped.
    read_en = 1'b1; read_addr = 16'h1407;
    tick();
    read_en = 1'b0;
    tick();
    rst = 1'b1;
    #2;
    check("rst mid-read vld", read_data_vld, 0);
    check("rst mid-read req", act_rd_req, 0);
    check("rst mid-read data", read_data, 0);
    tick();
    rst = 1'b0;
    act_rd_vld = 1'b1; act_rd_data = 16'hBEEF;
    tick();
    act_rd_vld = 1'b0;
    tick();
    check("late response vld", read_data_vld, 0);
    check("late response read_rdy", read_rdy, 1);
    check("late response data", read_data, 0);

    // Reset while BUSY abandons the computation.
    host_write(16'h8000, 32'h1);
    check("busy before rst", write_rdy, 0);
    rst = 1'b1;
    #2;
    check("rst mid-busy write_rdy", write_rdy, 1);
    check("rst mid-busy start", start, 0);
    tick();
    rst = 1'b0;
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    tick();
    check("rst mid-busy interrupt", interrupt, 0);

    // Randomized run against a transaction-level model.
    m_busy = 0; m_intr = 0; m_cfg_due = 0; m_start_due = 0;
    m_rd_out = 0; m_resp_given = 0; req_cyc = -1; vld_cyc = 0; wait_cnt = 0;
    m_cfg_a = '0; m_cfg_d = '0; m_pe = '0; m_aa = '0; m_rdata = '0;
    for (int k = 0; k < 3000; k++) begin
      check("rnd write_rdy", write_rdy, !m_busy);
      check("rnd interrupt", interrupt, m_intr);
      check("rnd start", start, m_start_due);
      check("rnd cfg_wr_en", cfg_wr_en, m_cfg_due);
      if (m_cfg_due) begin
        check("rnd cfg_addr", cfg_addr, m_cfg_a);
        check("rnd cfg_data", cfg_data, m_cfg_d);
      end
      check("rnd read_rdy", read_rdy, !m_rd_out && !m_busy);
      exp_req = m_rd_out && (k == req_cyc);
      check("rnd act_rd_req", act_rd_req, exp_req);
      if (exp_req) begin
        check("rnd act_rd_pe", act_rd_pe, m_pe);
        check("rnd act_rd_addr", act_rd_addr, m_aa);
      end
      exp_vld = m_rd_out && m_resp_given && (k >= vld_cyc);
      check("rnd read_data_vld", read_data_vld, exp_vld);
      if (exp_vld) check("rnd read_data", read_data, m_rdata);

      write_en = ($urandom % 3 == 0);
      case ($urandom % 4)
        0:       write_addr = 16'($urandom) & 16'h7FFF;
        1:       write_addr = 16'h8000;
        2:       write_addr = 16'h8002;
        default: write_addr = 16'h8000 | 16'($urandom);
      endcase
      write_data    = $urandom;
      calc_done     = ($urandom % 6 == 0);
      read_en       = ($urandom % 2 == 0);
      read_addr     = 16'($urandom);
      read_data_rdy = ($urandom % 2 == 0);
      drove_resp    = 0;
      if (m_rd_out && !m_resp_given && k > req_cyc) begin
        if (wait_cnt == 0) begin
          act_rd_vld = 1'b1; act_rd_data = 16'($urandom); drove_resp = 1;
        end else begin
          act_rd_vld = 1'b0; wait_cnt--;
        end
      end else begin
        act_rd_vld = ($urandom % 4 == 0); act_rd_data = 16'($urandom);
      end

      wr_acc = write_en && !m_busy;
      rd_acc = read_en && !m_rd_out && !m_busy;
      m_cfg_due = wr_acc && !write_addr[15];
      if (m_cfg_due) begin
        m_cfg_a = write_addr; m_cfg_d = write_data;
      end
      m_start_due = wr_acc && (write_addr == 16'h8000) && write_data[0];
      if (m_start_due || (wr_acc && write_addr == 16'h8002)) m_intr = 0;
      if (m_start_due) begin
        m_busy = 1;
      end else if (m_busy && calc_done) begin
        m_busy = 0; m_intr = 1;
      end
      if (rd_acc) begin
        m_rd_out = 1; m_resp_given = 0; req_cyc = k + 1;
        m_pe = read_addr[15:10]; m_aa = read_addr[5:0];
        wait_cnt = int'($urandom % 3);
      end else if (m_rd_out) begin
        if (drove_resp) begin
          idx12 = 12'(int'(m_aa) * 64 + int'(m_pe));
          m_rdata = {idx12, act_rd_data};
          m_resp_given = 1; vld_cyc = k + 1;
        end else if (m_resp_given && k >= vld_cyc && read_data_rdy) begin
          m_rd_out = 0;
        end
      end
      tick();
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
